// File: rtl/alu_multicycle_pkg.sv
// Shared encodings for the multi-cycle Hack ALU: operation codes and FSM states.
// Package is named alu_pkg so the core and top can share it under a short name.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_HACK = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_MODU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Command/result handshake bundle between the decode stage (master) and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             dz;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, op, out_ready,
    input  in_ready, out_valid, out, zr, ng, dz
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, op, out_ready,
    output in_ready, out_valid, out, zr, ng, dz
  );
endinterface

// File: rtl/alu_multicycle_core.sv
// Combinational Hack function unit. Also used with fixed control bits to produce
// the pre-processed operands x' and y' alone (add of the operand and a zeroed other side).
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o
);
  logic [WIDTH-1:0] xz, xp, yz, yp, fr;

  always_comb begin
    xz    = zx_i ? '0 : x_i;
    xp    = nx_i ? ~xz : xz;
    yz    = zy_i ? '0 : y_i;
    yp    = ny_i ? ~yz : yz;
    fr    = f_i ? (xp + yp) : (xp & yp);
    out_o = no_i ? ~fr : fr;
  end
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle Hack ALU: single-cycle Hack ops plus iterative MUL / DIVU / MODU,
// one bit per cycle, with valid/ready handshakes and registered result and flags.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_multicycle_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // a: product accumulator / partial remainder
  // b: shifting multiplicand / dividend-then-quotient
  // c: shifting multiplier / divisor
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d, dz_q, dz_d;

  logic [WIDTH-1:0] x_pre, y_pre, hack_res;
  logic [WIDTH-1:0] mul_acc, rem_next, quo_next;
  logic [WIDTH:0]   rem_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] res_c;
  logic             load_c;

  alu_core #(.WIDTH(WIDTH)) u_pre_x (
    .x_i(bus.x), .y_i(bus.y), .zx_i(bus.zx), .nx_i(bus.nx),
    .zy_i(1'b1), .ny_i(1'b0), .f_i(1'b1), .no_i(1'b0), .out_o(x_pre)
  );

  alu_core #(.WIDTH(WIDTH)) u_pre_y (
    .x_i(bus.x), .y_i(bus.y), .zx_i(1'b1), .nx_i(1'b0),
    .zy_i(bus.zy), .ny_i(bus.ny), .f_i(1'b1), .no_i(1'b0), .out_o(y_pre)
  );

  alu_core #(.WIDTH(WIDTH)) u_hack (
    .x_i(bus.x), .y_i(bus.y), .zx_i(bus.zx), .nx_i(bus.nx),
    .zy_i(bus.zy), .ny_i(bus.ny), .f_i(bus.f), .no_i(bus.no), .out_o(hack_res)
  );

  // One shift-add step and one restoring-division step, selected by op_q.
  // A zero divisor naturally yields an all-ones quotient and remainder == dividend.
  always_comb begin
    mul_acc   = c_q[0] ? (a_q + b_q) : a_q;
    rem_shift = {a_q, b_q[WIDTH-1]};
    div_ge    = (rem_shift >= {1'b0, c_q});
    div_diff  = rem_shift - {1'b0, c_q};
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {b_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    dz_d    = dz_q;
    res_c   = '0;
    load_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d  = op_e'(bus.op);
          cnt_d = '0;
          a_d   = '0;
          b_d   = x_pre;
          c_d   = y_pre;
          if (op_e'(bus.op) == OP_HACK) begin
            state_d = S_DONE;
            res_c   = hack_res;
            load_c  = 1'b1;
            dz_d    = 1'b0;
          end else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          a_d = mul_acc;
          b_d = b_q << 1;
          c_d = c_q >> 1;
        end else begin
          a_d = rem_next;
          b_d = quo_next;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          load_c  = 1'b1;
          case (op_q)
            OP_MUL:  res_c = mul_acc;
            OP_DIVU: res_c = quo_next;
            default: res_c = rem_next;
          endcase
          dz_d = (op_q != OP_MUL) && (c_q == '0);
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_c) begin
      out_d = res_c;
      zr_d  = (res_c == '0);
      ng_d  = res_c[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_HACK;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !reset;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.dz        = dz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=16: directed Hack/MUL/DIV cases,
// divide-by-zero, backpressure, mid-operation reset and a few random commands.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(16)) bus ();
  alu_multicycle #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bits = {zx, nx, zy, ny, f, no}
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic [5:0] b, input logic [1:0] op);
    exp_t        e;
    logic [15:0] xp, yp, r;
    logic [31:0] p;
    xp = b[5] ? 16'h0 : x;
    if (b[4]) xp = ~xp;
    yp = b[3] ? 16'h0 : y;
    if (b[2]) yp = ~yp;
    e.dz  = 1'b0;
    e.lat = (op == 2'b00) ? 1 : 17;
    case (op)
      2'b00: begin
        r = b[1] ? (xp + yp) : (xp & yp);
        if (b[0]) r = ~r;
      end
      2'b01: begin
        p = xp * yp;
        r = p[15:0];
      end
      2'b10: begin
        if (yp == 16'h0) begin r = 16'hFFFF; e.dz = 1'b1; end
        else r = xp / yp;
      end
      default: begin
        if (yp == 16'h0) begin r = xp; e.dz = 1'b1; end
        else r = xp % yp;
      end
    endcase
    e.res = r;
    return e;
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [5:0] b,
                      input logic [1:0] op, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    bus.x  = x;
    bus.y  = y;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) sb.push_back(model(x, y, b, op));
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    if (hold > 0) bus.out_ready = 1'b0;
    e = sb.pop_front();
    check("out_valid", bus.out_valid, 1);
    check("latency", lat, e.lat);
    check("out", bus.out, e.res);
    check("zr", bus.zr, (e.res == 16'h0));
    check("ng", bus.ng, e.res[15]);
    check("dz", bus.dz, e.dz);
    $display("[TB] txn out=%04h zr=%0b ng=%0b dz=%0b lat=%0d (exp %04h/%0b lat %0d)",
             bus.out, bus.zr, bus.ng, bus.dz, lat, e.res, e.dz, e.lat);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.x  = 16'($urandom);
      bus.op = 2'b00;
      @(negedge clk);
      check("bp_out", bus.out, e.res);
      check("bp_zr", bus.zr, (e.res == 16'h0));
      check("bp_ng", bus.ng, e.res[15]);
      check("bp_dz", bus.dz, e.dz);
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    if (hold > 0) begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_ready", bus.in_ready, 1);
    end
  endtask

  initial begin
    logic seen;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.x = 16'h0; bus.y = 16'h0; bus.op = 2'b00;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000010;

    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out", bus.out, 0);
      check("rst_flags", {bus.zr, bus.ng, bus.dz}, 0);
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Hack functions
    send(16'h1234, 16'h0011, 6'b000010, 2'b00, 1); collect(0);
    send(16'd5,    16'd7,    6'b010011, 2'b00, 1); collect(0);
    send(16'h1234, 16'h5678, 6'b101010, 2'b00, 1); collect(0);
    // Multiply
    send(16'd300,  16'd300,  6'b000000, 2'b01, 1); collect(0);
    send(16'hFFFD, 16'd7,    6'b000000, 2'b01, 1); collect(0);
    // Divide / modulo, including zero divisor
    send(16'd1000, 16'd7,    6'b000000, 2'b10, 1); collect(0);
    send(16'd1000, 16'd7,    6'b000000, 2'b11, 1); collect(0);
    send(16'd1000, 16'd0,    6'b000000, 2'b10, 1); collect(0);
    send(16'd1000, 16'd0,    6'b000000, 2'b11, 1); collect(0);
    // Backpressure, then a new command must still be accepted
    send(16'd1000, 16'd7,    6'b000000, 2'b10, 1); collect(5);
    send(16'd9,    16'd4,    6'b000010, 2'b00, 1); collect(0);

    // Reset during the 5th BUSY cycle of a MUL aborts it silently
    send(16'd300, 16'd300, 6'b000000, 2'b01, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("abort_no_valid", seen, 0);
    check("abort_out", bus.out, 0);
    send(16'd21, 16'd21, 6'b000010, 2'b00, 1); collect(0);

    // Random mix with operand pre-processing on every op
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom_range(0, 300)), 6'($urandom),
           2'($urandom_range(0, 3)), 1);
      collect(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
